// File: rtl/multi_stream_prefetch_ctrl.sv
// Multi-stream stride prefetcher: learns a stride per AXI ID from snooped
// demand reads and issues round-robin prefetches for confident streams.
module multi_stream_prefetch_ctrl #(
    parameter int unsigned ADDR_BITS       = 64,
    parameter int unsigned TID_WIDTH       = 8,
    parameter int unsigned BURST_LEN_WIDTH = 8,
    parameter int unsigned NUM_STREAMS     = 4,
    parameter int unsigned LOG_MAX_DEGREE  = 3,
    parameter int unsigned CONF_BITS       = 2,
    parameter int unsigned TIMEOUT_BITS    = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           ctrl_flush,
    input  logic                           obs_valid,
    input  logic [ADDR_BITS-1:0]           obs_addr,
    input  logic [TID_WIDTH-1:0]           obs_id,
    input  logic [BURST_LEN_WIDTH-1:0]     obs_len,
    output logic                           pf_valid,
    input  logic                           pf_ready,
    output logic [ADDR_BITS-1:0]           pf_addr,
    output logic [TID_WIDTH-1:0]           pf_id,
    output logic [BURST_LEN_WIDTH-1:0]     pf_len,
    output logic [$clog2(NUM_STREAMS)-1:0] pf_stream,
    input  logic                           pf_done_valid,
    input  logic [$clog2(NUM_STREAMS)-1:0] pf_done_stream,
    output logic [NUM_STREAMS-1:0]         flush_mask,
    input  logic [ADDR_BITS-1:0]           cfg_bar,
    input  logic [ADDR_BITS-1:0]           cfg_limit,
    input  logic [LOG_MAX_DEGREE:0]        cfg_degree,
    input  logic [CONF_BITS-1:0]           cfg_conf_thresh,
    input  logic [TIMEOUT_BITS-1:0]        cfg_timeout
);
    localparam int unsigned SW  = $clog2(NUM_STREAMS);
    localparam int unsigned OW  = LOG_MAX_DEGREE + 1;
    localparam int unsigned TW1 = TIMEOUT_BITS + 1;

    typedef enum logic [1:0] {ST_INVALID = 2'd0, ST_TRAIN = 2'd1, ST_ACTIVE = 2'd2} st_e;

    st_e                        state_q [NUM_STREAMS], state_d [NUM_STREAMS];
    logic [TID_WIDTH-1:0]       id_q    [NUM_STREAMS], id_d    [NUM_STREAMS];
    logic [BURST_LEN_WIDTH-1:0] len_q   [NUM_STREAMS], len_d   [NUM_STREAMS];
    logic [ADDR_BITS-1:0]       last_q  [NUM_STREAMS], last_d  [NUM_STREAMS];
    logic [ADDR_BITS-1:0]       stride_q[NUM_STREAMS], stride_d[NUM_STREAMS];
    logic [ADDR_BITS-1:0]       next_q  [NUM_STREAMS], next_d  [NUM_STREAMS];
    logic [CONF_BITS-1:0]       conf_q  [NUM_STREAMS], conf_d  [NUM_STREAMS];
    logic [OW-1:0]              outst_q [NUM_STREAMS], outst_d [NUM_STREAMS];
    logic [TIMEOUT_BITS-1:0]    idle_q  [NUM_STREAMS], idle_d  [NUM_STREAMS];

    logic [SW-1:0]              rr_q, rr_d, victim_q, victim_d;
    logic [NUM_STREAMS-1:0]     flush_d;
    logic                       pf_valid_d;
    logic [ADDR_BITS-1:0]       pf_addr_d;
    logic [TID_WIDTH-1:0]       pf_id_d;
    logic [BURST_LEN_WIDTH-1:0] pf_len_d;
    logic [SW-1:0]              pf_stream_d;

    logic                       obs_act, hit, free_v, len_chg, mismatch;
    logic [SW-1:0]              hit_idx, free_idx, tgt, cand, grant_idx;
    logic [ADDR_BITS-1:0]       delta;
    logic [CONF_BITS-1:0]       conf_inc;
    logic [NUM_STREAMS-1:0]     elig;
    logic                       grant_v;

    // Stream lookup by ID, lowest free entry, and stride comparison for the hit entry
    always_comb begin
        obs_act  = obs_valid && (obs_addr >= cfg_bar) && (obs_addr <= cfg_limit);
        hit      = 1'b0;
        hit_idx  = '0;
        free_v   = 1'b0;
        free_idx = '0;
        for (int i = int'(NUM_STREAMS) - 1; i >= 0; i--) begin
            if (state_q[i] != ST_INVALID && id_q[i] == obs_id) begin
                hit     = obs_act;
                hit_idx = SW'(i);
            end
            if (state_q[i] == ST_INVALID) begin
                free_v   = 1'b1;
                free_idx = SW'(i);
            end
        end
        delta    = obs_addr - last_q[hit_idx];
        len_chg  = obs_len != len_q[hit_idx];
        mismatch = len_chg || (delta != '0 && delta != stride_q[hit_idx]);
        conf_inc = (conf_q[hit_idx] == '1) ? conf_q[hit_idx] : conf_q[hit_idx] + CONF_BITS'(1);
        tgt      = free_v ? free_idx : victim_q;
    end

    // Round-robin arbiter: search starts just after the last granted entry
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < int'(NUM_STREAMS); i++) begin
            elig[i] = (state_q[i] == ST_ACTIVE) && (outst_q[i] < cfg_degree) &&
                      (next_q[i] >= cfg_bar) && (next_q[i] <= cfg_limit);
        end
        for (int unsigned k = NUM_STREAMS; k >= 1; k--) begin
            cand = SW'((32'(rr_q) + k) % NUM_STREAMS);
            if (elig[cand]) begin
                grant_v   = 1'b1;
                grant_idx = cand;
            end
        end
        grant_v = grant_v && en && !ctrl_flush && (!pf_valid || pf_ready);
    end

    // Next-state for the stream table, pointers and flush pulses
    always_comb begin
        for (int i = 0; i < int'(NUM_STREAMS); i++) begin
            state_d[i]  = state_q[i];
            id_d[i]     = id_q[i];
            len_d[i]    = len_q[i];
            last_d[i]   = last_q[i];
            stride_d[i] = stride_q[i];
            next_d[i]   = next_q[i];
            conf_d[i]   = conf_q[i];
            outst_d[i]  = outst_q[i];
            idle_d[i]   = idle_q[i];
        end
        rr_d     = rr_q;
        victim_d = victim_q;
        flush_d  = '0;
        if (en && ctrl_flush) begin
            for (int i = 0; i < int'(NUM_STREAMS); i++) begin
                flush_d[i] = state_q[i] != ST_INVALID;
                state_d[i] = ST_INVALID;
                outst_d[i] = '0;
                idle_d[i]  = '0;
            end
        end else if (en) begin
            if (grant_v) rr_d = grant_idx;
            if (obs_act && !hit && !free_v)
                victim_d = (victim_q == SW'(NUM_STREAMS - 1)) ? '0 : victim_q + SW'(1);
            for (int i = 0; i < int'(NUM_STREAMS); i++) begin
                if (grant_v && grant_idx == SW'(i)) begin
                    next_d[i]  = next_q[i] + stride_q[i];
                    outst_d[i] = outst_q[i] + OW'(1);
                end
                if (pf_done_valid && pf_done_stream == SW'(i) && outst_q[i] != '0)
                    outst_d[i] = outst_d[i] - OW'(1);
                if (state_q[i] != ST_INVALID && cfg_timeout != '0 && !(hit && hit_idx == SW'(i))) begin
                    if (TW1'(idle_q[i]) + TW1'(1) >= TW1'(cfg_timeout)) begin
                        state_d[i] = ST_INVALID;
                        outst_d[i] = '0;
                        idle_d[i]  = '0;
                        flush_d[i] = 1'b1;
                    end else begin
                        idle_d[i] = idle_q[i] + TIMEOUT_BITS'(1);
                    end
                end
                if (hit && hit_idx == SW'(i)) begin
                    last_d[i] = obs_addr;
                    idle_d[i] = '0;
                    if (mismatch) begin
                        stride_d[i] = delta;
                        conf_d[i]   = '0;
                        len_d[i]    = obs_len;
                        if (state_q[i] == ST_ACTIVE) begin
                            state_d[i] = ST_TRAIN;
                            flush_d[i] = 1'b1;
                        end else if (delta != '0 && cfg_conf_thresh == '0) begin
                            state_d[i] = ST_ACTIVE;
                            next_d[i]  = obs_addr + delta;
                        end
                    end else if (delta != '0) begin
                        conf_d[i] = conf_inc;
                        if (state_q[i] == ST_TRAIN && conf_inc >= cfg_conf_thresh) begin
                            state_d[i] = ST_ACTIVE;
                            next_d[i]  = obs_addr + stride_q[i];
                        end
                    end
                end
                if (obs_act && !hit && tgt == SW'(i)) begin
                    if (!free_v) flush_d[i] = 1'b1;
                    state_d[i]  = ST_TRAIN;
                    id_d[i]     = obs_id;
                    len_d[i]    = obs_len;
                    last_d[i]   = obs_addr;
                    stride_d[i] = '0;
                    next_d[i]   = '0;
                    conf_d[i]   = '0;
                    outst_d[i]  = '0;
                    idle_d[i]   = '0;
                end
            end
        end
    end

    // Prefetch output register: load on grant, drop on accept or flush
    always_comb begin
        pf_valid_d  = pf_valid;
        pf_addr_d   = pf_addr;
        pf_id_d     = pf_id;
        pf_len_d    = pf_len;
        pf_stream_d = pf_stream;
        if (en) begin
            if (ctrl_flush) begin
                pf_valid_d = 1'b0;
            end else if (grant_v) begin
                pf_valid_d  = 1'b1;
                pf_addr_d   = next_q[grant_idx];
                pf_id_d     = id_q[grant_idx];
                pf_len_d    = len_q[grant_idx];
                pf_stream_d = grant_idx;
            end else if (pf_ready) begin
                pf_valid_d = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_STREAMS); i++) begin
                state_q[i]  <= ST_INVALID;
                id_q[i]     <= '0;
                len_q[i]    <= '0;
                last_q[i]   <= '0;
                stride_q[i] <= '0;
                next_q[i]   <= '0;
                conf_q[i]   <= '0;
                outst_q[i]  <= '0;
                idle_q[i]   <= '0;
            end
            rr_q       <= '0;
            victim_q   <= '0;
            flush_mask <= '0;
            pf_valid   <= 1'b0;
            pf_addr    <= '0;
            pf_id      <= '0;
            pf_len     <= '0;
            pf_stream  <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_STREAMS); i++) begin
                state_q[i]  <= state_d[i];
                id_q[i]     <= id_d[i];
                len_q[i]    <= len_d[i];
                last_q[i]   <= last_d[i];
                stride_q[i] <= stride_d[i];
                next_q[i]   <= next_d[i];
                conf_q[i]   <= conf_d[i];
                outst_q[i]  <= outst_d[i];
                idle_q[i]   <= idle_d[i];
            end
            rr_q       <= rr_d;
            victim_q   <= victim_d;
            flush_mask <= flush_d;
            pf_valid   <= pf_valid_d;
            pf_addr    <= pf_addr_d;
            pf_id      <= pf_id_d;
            pf_len     <= pf_len_d;
            pf_stream  <= pf_stream_d;
        end
    end

endmodule

// File: tb/tb_multi_stream_prefetch_ctrl.sv
// Directed bench for multi_stream_prefetch_ctrl with hand-computed expectations.
module tb_multi_stream_prefetch_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        ctrl_flush;
    logic        obs_valid;
    logic [63:0] obs_addr;
    logic [7:0]  obs_id;
    logic [7:0]  obs_len;
    logic        pf_valid;
    logic        pf_ready;
    logic [63:0] pf_addr;
    logic [7:0]  pf_id;
    logic [7:0]  pf_len;
    logic [1:0]  pf_stream;
    logic        pf_done_valid;
    logic [1:0]  pf_done_stream;
    logic [3:0]  flush_mask;
    logic [63:0] cfg_bar;
    logic [63:0] cfg_limit;
    logic [3:0]  cfg_degree;
    logic [1:0]  cfg_conf_thresh;
    logic [9:0]  cfg_timeout;

    int checks = 0;
    int errors = 0;

    multi_stream_prefetch_ctrl dut (
        .clk(clk), .reset(reset), .en(en), .ctrl_flush(ctrl_flush),
        .obs_valid(obs_valid), .obs_addr(obs_addr), .obs_id(obs_id), .obs_len(obs_len),
        .pf_valid(pf_valid), .pf_ready(pf_ready), .pf_addr(pf_addr), .pf_id(pf_id),
        .pf_len(pf_len), .pf_stream(pf_stream), .pf_done_valid(pf_done_valid),
        .pf_done_stream(pf_done_stream), .flush_mask(flush_mask), .cfg_bar(cfg_bar),
        .cfg_limit(cfg_limit), .cfg_degree(cfg_degree), .cfg_conf_thresh(cfg_conf_thresh),
        .cfg_timeout(cfg_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_v(input string tag, input logic exp_v);
        chk({tag, "_valid"}, 64'(pf_valid), 64'(exp_v));
    endtask

    task automatic chk_a(input string tag, input logic [63:0] exp_a, input logic [1:0] exp_s);
        chk({tag, "_valid"}, 64'(pf_valid), 64'd1);
        chk({tag, "_addr"}, pf_addr, exp_a);
        chk({tag, "_stream"}, 64'(pf_stream), 64'(exp_s));
    endtask

    task automatic chk_f(input string tag, input logic [3:0] exp_m);
        chk({tag, "_flush"}, 64'(flush_mask), 64'(exp_m));
    endtask

    task automatic observe(input logic [7:0] id, input logic [63:0] addr);
        obs_valid = 1'b1;
        obs_id    = id;
        obs_addr  = addr;
        obs_len   = 8'd3;
        tick();
        obs_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        chk({tag, "_rst_valid"}, 64'(pf_valid), 64'd0);
        chk({tag, "_rst_addr"}, pf_addr, 64'd0);
        chk({tag, "_rst_idlen"}, 64'({pf_id, pf_len, pf_stream}), 64'd0);
        chk({tag, "_rst_flush"}, 64'(flush_mask), 64'd0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; en = 1'b1; ctrl_flush = 1'b0; obs_valid = 1'b0;
        obs_addr = '0; obs_id = '0; obs_len = 8'd3; pf_ready = 1'b0;
        pf_done_valid = 1'b0; pf_done_stream = '0;
        cfg_bar = 64'h1000; cfg_limit = 64'h1FFF; cfg_degree = 4'd2;
        cfg_conf_thresh = 2'd1; cfg_timeout = 10'd0;

        // Single stream: training, degree limit, enable hold, credit return
        do_reset("t1");
        observe(8'd5, 64'h1000);
        observe(8'd5, 64'h1040);
        observe(8'd5, 64'h1080);
        chk_v("t1_not_yet", 1'b0);
        observe(8'd5, 64'h10C0);
        chk_a("t1_first", 64'h10C0, 2'd0);
        chk("t1_first_id", 64'(pf_id), 64'd5);
        chk("t1_first_len", 64'(pf_len), 64'd3);
        en = 1'b0; pf_ready = 1'b1;
        tick();
        chk_a("t1_en_hold", 64'h10C0, 2'd0);
        en = 1'b1;
        tick();
        chk_a("t1_second", 64'h1100, 2'd0);
        tick();
        chk_v("t1_degree_cap", 1'b0);
        pf_done_valid = 1'b1; pf_done_stream = 2'd0;
        tick();
        pf_done_valid = 1'b0;
        chk_v("t1_done_cycle", 1'b0);
        tick();
        chk_a("t1_third", 64'h1140, 2'd0);

        // Two interleaved streams alternate grants
        pf_ready = 1'b1;
        do_reset("t2");
        observe(8'd1, 64'h1000);
        observe(8'd2, 64'h1800);
        observe(8'd1, 64'h1040);
        observe(8'd2, 64'h1780);
        observe(8'd1, 64'h1080);
        chk_v("t2_idle", 1'b0);
        observe(8'd2, 64'h1700);
        chk_a("t2_g0", 64'h10C0, 2'd0);
        chk("t2_g0_id", 64'(pf_id), 64'd1);
        tick();
        chk_a("t2_g1", 64'h1680, 2'd1);
        chk("t2_g1_id", 64'(pf_id), 64'd2);
        tick();
        chk_a("t2_g2", 64'h1100, 2'd0);
        tick();
        chk_a("t2_g3", 64'h1600, 2'd1);
        tick();
        chk_v("t2_cap", 1'b0);

        // Stride break on an active stream
        observe(8'd1, 64'h1180);
        chk_f("t3_break", 4'b0001);
        pf_done_valid = 1'b1; pf_done_stream = 2'd0;
        tick();
        chk_f("t3_pulse_end", 4'b0000);
        tick();
        pf_done_valid = 1'b0;
        tick();
        tick();
        chk_v("t3_training", 1'b0);
        observe(8'd1, 64'h1280);
        chk_v("t3_reconf", 1'b0);
        tick();
        chk_a("t3_resume", 64'h1380, 2'd0);

        // Replacement when the table is full
        pf_ready = 1'b0;
        do_reset("t4");
        observe(8'd10, 64'h1000);
        observe(8'd11, 64'h1000);
        observe(8'd12, 64'h1000);
        observe(8'd13, 64'h1000);
        chk_f("t4_fill", 4'b0000);
        observe(8'd14, 64'h1000);
        chk_f("t4_victim0", 4'b0001);
        observe(8'd15, 64'h1000);
        chk_f("t4_victim1", 4'b0010);
        tick();
        chk_f("t4_quiet", 4'b0000);

        // Idle timeout invalidates the stream and clears its credits
        cfg_timeout = 10'd16;
        do_reset("t5");
        observe(8'd5, 64'h1000);
        observe(8'd5, 64'h1040);
        observe(8'd5, 64'h1080);
        repeat (14) tick();
        tick();
        chk_f("t5_idle15", 4'b0000);
        chk_a("t5_pending", 64'h10C0, 2'd0);
        tick();
        chk_f("t5_timeout", 4'b0001);
        pf_done_valid = 1'b1; pf_done_stream = 2'd0; pf_ready = 1'b1;
        tick();
        pf_done_valid = 1'b0;
        chk_f("t5_after", 4'b0000);
        chk_v("t5_drained", 1'b0);
        observe(8'd5, 64'h1400);
        chk_f("t5_realloc", 4'b0000);
        observe(8'd5, 64'h1440);
        observe(8'd5, 64'h1480);
        tick();
        chk_a("t5_new0", 64'h14C0, 2'd0);
        tick();
        chk_a("t5_new1", 64'h1500, 2'd0);
        tick();
        chk_v("t5_cap", 1'b0);

        // Window limit stops issue; ctrl_flush drops a stalled request
        cfg_timeout = 10'd0;
        pf_ready = 1'b1;
        do_reset("t6");
        observe(8'd7, 64'h1F00);
        observe(8'd7, 64'h1F40);
        observe(8'd7, 64'h1F80);
        tick();
        chk_a("t6_last", 64'h1FC0, 2'd0);
        tick();
        chk_v("t6_limit", 1'b0);
        tick();
        chk_v("t6_limit2", 1'b0);
        pf_ready = 1'b0;
        observe(8'd8, 64'h1100);
        observe(8'd8, 64'h1140);
        observe(8'd8, 64'h1180);
        tick();
        chk_a("t6_stalled", 64'h11C0, 2'd1);
        ctrl_flush = 1'b1;
        tick();
        ctrl_flush = 1'b0;
        chk_v("t6_flush_drop", 1'b0);
        chk_f("t6_flush", 4'b0011);
        pf_ready = 1'b1;
        observe(8'd8, 64'h11C0);
        chk_f("t6_post", 4'b0000);
        chk_v("t6_post", 1'b0);
        tick();
        chk_v("t6_post2", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_stream_prefetch_ctrl.md
Name: multi_stream_prefetch_ctrl

Overview:
- Stride-prefetch controller that tracks up to NUM_STREAMS independent read streams, keyed by AXI ID, instead of a single stream.
- It snoops accepted demand read requests and learns a per-stream stride with a confidence counter.
- Once a stream is confident, it issues prefetch requests up to cfg_degree blocks ahead, with round-robin arbitration between streams.
- It sits between the AXI slave AR snoop point and the prefetch queue/AR issue logic. It drives per-stream flush requests toward the queue.

Parameters:
- ADDR_BITS, 64: address width.
- TID_WIDTH, 8: AXI ID width.
- BURST_LEN_WIDTH, 8: AXI len width.
- NUM_STREAMS, 4: number of stream table entries (2..16).
- LOG_MAX_DEGREE, 3: per-stream outstanding counter holds 0..2^LOG_MAX_DEGREE.
- CONF_BITS, 2: confidence counter width.
- TIMEOUT_BITS, 10: idle timer width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  global enable; low freezes all state
- ctrl_flush  in  1  invalidate all streams
- obs_valid  in  1  a demand AR handshake occurred this cycle
- obs_addr  in  ADDR_BITS  demand address
- obs_id  in  TID_WIDTH  demand ID
- obs_len  in  BURST_LEN_WIDTH  demand burst length
- pf_valid  out  1  prefetch request valid
- pf_ready  in  1  prefetch request accepted
- pf_addr  out  ADDR_BITS  prefetch address
- pf_id  out  TID_WIDTH  stream ID
- pf_len  out  BURST_LEN_WIDTH  stream burst length
- pf_stream  out  $clog2(NUM_STREAMS)  issuing entry index
- pf_done_valid  in  1  a prefetched block was consumed or dropped
- pf_done_stream  in  $clog2(NUM_STREAMS)  entry to credit
- flush_mask  out  NUM_STREAMS  one-cycle pulse per entry whose queued blocks must be flushed
- cfg_bar, cfg_limit  in  ADDR_BITS  inclusive prefetch window
- cfg_degree  in  LOG_MAX_DEGREE+1  max outstanding per stream (0 disables issue)
- cfg_conf_thresh  in  CONF_BITS  confirmations required before ACTIVE
- cfg_timeout  in  TIMEOUT_BITS  idle cycles before invalidation (0 disables)

Behaviour:
- Reset: all entries INVALID with fields zeroed. pf_valid=0, pf_addr/pf_id/pf_len/pf_stream=0, flush_mask=0, round-robin and victim pointers=0.
- Entry fields: state {INVALID, TRAIN, ACTIVE}, id, len, last_addr, stride (signed, modulo 2^ADDR_BITS), conf (saturating), next_addr, outstanding, idle timer.
- Observation with obs_addr outside [cfg_bar, cfg_limit]: ignored.
- Lookup is by id among non-INVALID entries.
- Observation miss: allocate the lowest-index INVALID entry. If none is INVALID, replace the entry at the victim pointer, pulse its flush_mask bit, and increment the victim pointer (wraps).
  - New entry: TRAIN, stride=0, conf=0, outstanding=0, last_addr=obs_addr, id/len latched.
- Observation hit: d = obs_addr - last_addr; last_addr<=obs_addr; idle timer cleared.
  - d==0: no other change.
  - d!=0 and d==stride: conf++ (saturating).
  - d!=0 and d!=stride: stride<=d, conf<=0. If the entry was ACTIVE, it returns to TRAIN and its flush_mask bit pulses.
  - len differs from the latched len: treated as a stride mismatch and len is relatched.
- TRAIN->ACTIVE: occurs on a hit where stride!=0 and the post-update conf>=cfg_conf_thresh. On entry, next_addr<=obs_addr+stride (wraps mod 2^ADDR_BITS).
- Issue eligibility: ACTIVE, outstanding<cfg_degree, and next_addr within [cfg_bar, cfg_limit]. Out-of-range entries stay ACTIVE and issue nothing.
- Arbiter: round-robin starting after the last granted entry. The grant loads the output register when pf_valid==0 or pf_ready==1 (back-to-back issue allowed).
  - Granted entry: next_addr+=stride, outstanding++.
- Output: pf_* are registered. Once pf_valid=1, pf_* hold until pf_ready, except on ctrl_flush, which drops pf_valid. Latency from the first eligible cycle to pf_valid is 1 cycle.
- pf_done_valid: decrements outstanding of pf_done_stream. It is ignored if outstanding==0. Grant and done on the same entry in the same cycle leave outstanding unchanged.
- Timeout: when cfg_timeout!=0, the idle timer increments each enabled cycle. Reaching cfg_timeout sets the entry INVALID, clears outstanding, and pulses its flush_mask bit.
- ctrl_flush: has priority over everything else.
  - All entries INVALID; flush_mask = bitmap of previously non-INVALID entries; pf_valid<=0.
  - obs is ignored in that cycle.
- Observation update and grant on the same entry in the same cycle: the grant uses the pre-update next_addr. The observation update then wins for stride/state/next_addr.
- en=0: no state change, pf_* held, flush_mask=0, inputs ignored.
- Reset mid-operation: immediate return to reset values; no flush pulse is generated.

Test Plan:
- ID 5, len 3, addrs 0x1000, 0x1040, 0x1080, 0x10C0, cfg_conf_thresh=1, cfg_degree=2 -> ACTIVE after the 3rd obs; pf_addr 0x10C0, then 0x1100; third issue only after a pf_done.
- Interleaved IDs 1 (stride +0x40) and 2 (stride -0x80), both ACTIVE, pf_ready=1 -> pf_stream alternates 0,1,0,1 with correct per-stream addresses.
- ACTIVE stream ID 1 gets addr delta +0x100 -> flush_mask bit pulses one cycle, entry in TRAIN, no further pf for that stream until reconfirmed.
- NUM_STREAMS+1 distinct IDs observed -> entry 0 replaced, flush_mask=0b0001 pulse, victim pointer=1.
- ACTIVE stream, cfg_timeout=16, no obs -> flush pulse at idle cycle 16, entry INVALID, pending pf_done ignored.
- next_addr passes cfg_limit=0x1FFF -> issuing stops at 0x1FC0; ctrl_flush with pf_valid=1 and pf_ready=0 -> pf_valid=0 next cycle, all entries invalidated.
